// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, transfer record and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

  // Default geometry shared with the APB slave blocks on the same fabric.
  localparam int APB_NUM_REQ   = 4;
  localparam int APB_ADDRWIDTH = 8;
  localparam int APB_DATAWIDTH = 16;
  localparam int APB_TIMEOUT   = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // One APB transfer at the default fabric widths.
  typedef struct packed {
    logic [APB_ADDRWIDTH-1:0] addr;
    logic [APB_DATAWIDTH-1:0] wdata;
    logic                     write;
  } apb_xfer_t;

  // Round-robin successor of idx in a ring of n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Bundle of the requester-side and APB-side signals of the shared APB master.
// Latency: n/a (wiring only).
// Backpressure: req_valid is held by a requester until its req_ready pulse.
// Ports (master = arbiter side):
//   req_valid/req_write/req_addr/req_wdata -> arbiter, req_ready <- arbiter
//   rsp_valid/rsp_rdata/rsp_err <- arbiter
//   psel/penable/pwrite/paddr/pwdata <- arbiter, prdata/pready/pslverr -> arbiter
interface apb_req_arbiter_if
  import apb_pkg::*;
#(
  parameter int NUM_REQ   = APB_NUM_REQ,
  parameter int DATAWIDTH = APB_DATAWIDTH,
  parameter int ADDRWIDTH = APB_ADDRWIDTH
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_write;
  logic [NUM_REQ*ADDRWIDTH-1:0] req_addr;
  logic [NUM_REQ*DATAWIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]           req_ready;

  logic [NUM_REQ-1:0]           rsp_valid;
  logic [DATAWIDTH-1:0]         rsp_rdata;
  logic                         rsp_err;

  logic                         psel;
  logic                         penable;
  logic                         pwrite;
  logic [ADDRWIDTH-1:0]         paddr;
  logic [DATAWIDTH-1:0]         pwdata;
  logic [DATAWIDTH-1:0]         prdata;
  logic                         pready;
  logic                         pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted req at or after rr_ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: grant is forced to zero while en=0; winner is still computed.
// Ports: req (request vector), rr_ptr (search start), en (arbitration allowed),
//        grant (one-hot), winner (index of the chosen requester).
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   winner
);

  logic             found;
  logic [PTR_W:0]   cand;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // One extra bit so rr_ptr + k never overflows before the wrap.
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!found && req[cand[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[PTR_W-1:0];
      end
    end
    if (en && found) begin
      grant[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB bus among NUM_REQ requesters with round-robin arbitration,
// wait-state/timeout handling and per-requester responses.
// Latency: grant->rsp_valid = 3 cycles + wait states; TIMEOUT+3 on timeout.
// Backpressure: one transfer outstanding; requests wait (req_valid held) until req_ready.
// Ports: clk, rst_n (async active-low), bus (apb_req_arbiter_if.master: requester
//        request/grant, response, and APB master signals).
module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter  int NUM_REQ   = APB_NUM_REQ,
  parameter  int DATAWIDTH = APB_DATAWIDTH,
  parameter  int ADDRWIDTH = APB_ADDRWIDTH,
  parameter  int TIMEOUT   = APB_TIMEOUT,
  localparam int PTR_W     = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  apb_req_arbiter_if.master bus
);

  typedef struct packed {
    logic [ADDRWIDTH-1:0] addr;
    logic [DATAWIDTH-1:0] wdata;
    logic                 write;
  } xfer_t;

  apb_state_t           state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [PTR_W-1:0]     owner_q;
  logic [CNT_W-1:0]     cnt_q;
  xfer_t                xfer_q;

  logic [NUM_REQ-1:0]   grant;
  logic [PTR_W-1:0]     winner;
  logic                 any_grant;
  logic                 arb_en;
  logic                 at_limit;
  logic                 timed_out;
  logic                 complete;
  logic [ADDRWIDTH-1:0] addr_sel;
  logic [DATAWIDTH-1:0] wdata_sel;
  logic                 write_sel;
  logic [NUM_REQ-1:0]   owner_onehot;

  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [DATAWIDTH-1:0] rsp_rdata_q;
  logic                 rsp_err_q;

  // pready wins over the timeout if both land on the same cycle.
  assign at_limit  = (cnt_q == CNT_W'(TIMEOUT));
  assign timed_out = (state_q == ACCESS) && !bus.pready && at_limit;
  assign complete  = (state_q == ACCESS) && (bus.pready || at_limit);

  // Arbitrate when idle, or on the completing ACCESS cycle so that a
  // waiting requester goes straight to SETUP with no idle gap.
  // rst_n gates the grant so req_ready stays low throughout reset.
  assign arb_en    = rst_n && ((state_q == IDLE) || complete);
  assign any_grant = |grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr_q),
    .en     (arb_en),
    .grant  (grant),
    .winner (winner)
  );

  assign bus.req_ready = grant;

  // Select the winner's transfer fields out of the packed request buses.
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    write_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == PTR_W'(i)) begin
        addr_sel  = bus.req_addr[i*ADDRWIDTH +: ADDRWIDTH];
        wdata_sel = bus.req_wdata[i*DATAWIDTH +: DATAWIDTH];
        write_sel = bus.req_write[i];
      end
    end
  end

  always_comb begin
    owner_onehot          = '0;
    owner_onehot[owner_q] = 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_grant) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (complete) state_d = any_grant ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, round-robin pointer and transfer latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      xfer_q   <= '0;
    end else begin
      state_q <= state_d;
      if (any_grant) begin
        xfer_q.addr  <= addr_sel;
        xfer_q.wdata <= wdata_sel;
        xfer_q.write <= write_sel;
        owner_q      <= winner;
        rr_ptr_q     <= PTR_W'(rr_next(int'(winner), NUM_REQ));
      end
    end
  end

  // ACCESS wait counter: cleared in SETUP, saturates at TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if ((state_q == ACCESS) && !bus.pready && !at_limit) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Response registers: one-cycle rsp_valid pulse to the owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= complete ? owner_onehot : '0;
      if (complete) begin
        rsp_rdata_q <= (timed_out || xfer_q.write) ? '0 : bus.prdata;
        rsp_err_q   <= timed_out ? 1'b1 : bus.pslverr;
      end
    end
  end

  assign bus.psel      = (state_q != IDLE);
  assign bus.penable   = (state_q == ACCESS);
  assign bus.pwrite    = xfer_q.write;
  assign bus.paddr     = xfer_q.addr;
  assign bus.pwdata    = xfer_q.wdata;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Multi-requester APB master that shares one APB bus, and the register/memory slaves behind it, among NUM_REQ internal requesters. It arbitrates round-robin, drives the APB SETUP/ACCESS phases with wait-state and timeout handling, and returns read data and error status to the requester that issued the transfer. It sits between the processing blocks and the APB slave fabric.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATAWIDTH, 16, APB data width
- ADDRWIDTH, 8, APB address width
- TIMEOUT, 15, max ACCESS cycles waiting for pready before forced error (1..255)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester transfer request, held until granted
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDRWIDTH  packed addresses, requester i at [i*ADDRWIDTH +: ADDRWIDTH]
- req_wdata  in  NUM_REQ*DATAWIDTH  packed write data
- req_ready  out  NUM_REQ  one-hot grant pulse, combinational
- rsp_valid  out  NUM_REQ  one-hot completion pulse, registered
- rsp_rdata  out  DATAWIDTH  read data, valid with rsp_valid
- rsp_err  out  1  pslverr or timeout, valid with rsp_valid
- psel, penable, pwrite  out  1 each  APB control
- paddr  out  ADDRWIDTH;  pwdata  out  DATAWIDTH
- prdata  in  DATAWIDTH;  pready  in  1;  pslverr  in  1  (slaves without these tie pready=1, pslverr=0)

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- Grant occurs in IDLE, or in ACCESS on the completing cycle, when any req_valid=1. Winner is the first set req_valid at or after rr_ptr, wrapping modulo NUM_REQ. req_ready[winner]=1 in that cycle only. addr/wdata/write/owner are latched at the edge, rr_ptr <= winner+1 mod NUM_REQ, next state is SETUP.
- SETUP: psel=1, penable=0, paddr/pwdata/pwrite from the latch. Always one cycle, then ACCESS. Timeout counter cleared.
- ACCESS: psel=1, penable=1, outputs stable. On pready=1: rsp_rdata <= prdata for reads, 0 for writes; rsp_err <= pslverr; rsp_valid[owner] pulses next cycle. Otherwise the counter increments. When the counter equals TIMEOUT with pready=0, the transfer completes with rsp_err=1 and rsp_rdata=0.
- On completion: go to SETUP if a new grant is made (back-to-back, no idle cycle), else go to IDLE with psel=0 and penable=0.
- Requesters must hold req_addr, req_wdata and req_write stable while req_valid=1. Deasserting req_valid before grant withdraws the request.
- A requester may re-request before its rsp_valid arrives. Responses are strictly in grant order, because only one transfer is outstanding.
- Counter width is clog2(TIMEOUT+1). It saturates and never wraps.

## Timing
- Reset (async, immediate): state=IDLE, rr_ptr=0, counter=0. psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err = 0. req_ready=0 while rst_n=0.
- Reset mid-transfer aborts it with no rsp_valid. The first grant after release starts at rr_ptr=0.
- Zero-wait transfer, req_valid=1 in IDLE at T0: req_ready at T0, SETUP at T1, ACCESS at T2 with pready=1, rsp_valid at T3. Request-to-response is 3 cycles.
- Each wait state adds one cycle. Timeout response arrives TIMEOUT+3 cycles after grant.
- Back-to-back throughput: one transfer per 2 cycles with zero wait states.
- Simultaneous requests: exactly one grant per arbitration cycle. A requester whose req_valid stays high is granted within NUM_REQ arbitrations.
- pready while not in ACCESS is ignored.

## Structure
- Shared package apb_pkg: state enum (IDLE, SETUP, ACCESS), APB transfer struct (addr, wdata, write), and default width constants shared with the APB slave blocks.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector, rr_ptr, and enable; outputs one-hot grant and winner index. Purely combinational.
- The top level holds the FSM, transfer latch, timeout counter, and response registers.

## Test plan
- Single write then read: requester 1 writes 0xBEEF to 0x10, then reads 0x10 through a memory slave model. Expect APB SETUP→ACCESS sequencing, rsp_valid[1] at T3 each time, read rsp_rdata=0xBEEF, rsp_err=0.
- All 4 requesters assert together from reset. Expect grant order 0,1,2,3, back-to-back transfers 2 cycles apart, and psel high continuously.
- Wait states: slave holds pready=0 for 3 cycles. Expect ACCESS held with stable paddr and pwdata, and rsp_valid 6 cycles after grant.
- Timeout: pready stuck at 0. Expect rsp_err=1, rsp_rdata=0, rsp_valid 18 cycles after grant, then the next request is served normally. pslverr=1 on a read yields rsp_err=1.
- Fairness: requester 0 asserts req_valid continuously while requester 2 requests once. Expect requester 2 granted at the next arbitration after the current transfer.
- Reset mid-ACCESS: drop rst_n during a write. Expect all outputs 0 immediately, no rsp_valid, and the next grant taken from rr_ptr=0.
